vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
// Parametrised successor to the fixed 640x480 VGA port: generates H/V timing from sysclk via pixel-enable divider,
// issues {y,x} pixel addresses to the selected function's frame source, registers returned colour, drives
// VGA pins with syncs pipeline-aligned to pixel data. Sits after container_switcher; adds multi-bit colour,
// configurable timing/polarity and a frame_start strobe for function blocks to sync frame-level updates.
// PARAMETERS
// H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (H_TOTAL = sum = 800)
// V_ACTIVE 480 visible lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33  (V_TOTAL = sum = 525)
// CLK_DIV  2   sysclk cycles per pixel (>=2); FETCH_LAT 1 sysclk cycles addr->data, must be < CLK_DIV
// COLOR_W  1   bits per channel; pixel_data = {R,G,B}, 3*COLOR_W bits
// X_W 11, Y_W 11  coordinate widths; pixel_addr = {y,x}, X_W+Y_W bits (default 22)
// HS_POL 0, VS_POL 0  sync active level (0 = active-low)
// PORTS
// sysclk       in   1            system clock
// rst          in   1            synchronous active-high reset
// pixel_data   in   3*COLOR_W    colour for last issued pixel_addr, valid FETCH_LAT cycles after it
// blank        in   1            force black on visible pixels (syncs unaffected)
// pattern_en   in   1            select built-in colour bars (only with SCANOUT_PATTERN_EN)
// pixel_addr   out  X_W+Y_W      {y,x} of pixel being fetched; held outside active area
// VGA_R/G/B    out  COLOR_W each colour to DAC/pins
// VGA_HS       out  1            horizontal sync
// VGA_VS       out  1            vertical sync
// frame_start  out  1            1-sysclk pulse when pixel (0,0) address is issued
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): div_cnt=0, h=0, v=0, pixel_addr=0, RGB=0, HS=~HS_POL, VS=~VS_POL,
//   frame_start=0; pipeline flags cleared. Mid-frame reset: restart at (0,0) next cycle, no partial sync.
// - pix_en = (div_cnt==CLK_DIV-1); div_cnt wraps to 0. All stages advance only on pix_en.
// - Stage 0 (counters): h 0..H_TOTAL-1 wraps to 0; on h wrap, v increments, wraps at V_TOTAL-1->0.
//   active = h<H_ACTIVE && v<V_ACTIVE; hs_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1];
//   vs_raw = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (whole lines).
// - Stage 1 (fetch): on pix_en, if active, pixel_addr <= {v[Y_W-1:0], h[X_W-1:0]}; else hold.
//   active/hs/vs registered alongside. frame_start=1 in the cycle pixel_addr<= {0,0} (h=0,v=0 & pix_en).
// - Stage 2 (output): on next pix_en, RGB <= (active1 && !blank) ? pixel_data : 0;
//   HS <= hs1 ? HS_POL : ~HS_POL; VS likewise. Latency counter->pins = 2 pixel periods, identical for
//   colour and syncs. pixel_data sampled CLK_DIV cycles after addr update, so FETCH_LAT<CLK_DIV suffices.
// - Blanking: RGB exactly 0 in porches/sync regardless of pixel_data.
// - blank sampled at stage 2 pix_en; changes mid-line take effect on the next output pixel, no glitch.
// - Counter widths: ceil(log2(H_TOTAL)), ceil(log2(V_TOTAL)); H_ACTIVE<=2^X_W, V_ACTIVE<=2^Y_W (elab check).
// CONFIGURATION
// SCANOUT_PATTERN_EN defined: pattern_en=1 replaces pixel_data at stage 2 with 8 vertical bars, bar index
//   = x*8/H_ACTIVE (from stage-1 x), colour = {R,G,B} all-ones/zeros per bits {b2,b1,b0} of bar index;
//   blank still overrides. pixel_addr still issued. pattern_en sampled at stage 2 pix_en.
// Not defined: pattern_en ignored (leave unconnected/tie 0); no pattern logic synthesised.
// TESTING (small config: H 8/2/3/1, V 4/1/2/1, CLK_DIV=2, FETCH_LAT=1, COLOR_W=2, HS/VS_POL=0)
// - Free-run 3 frames -> HS low 3 pixels (6 sysclk) every 14 pixels; VS low 2 lines (28 pixels) every 8 lines.
// - Source data = x+4*y -> pins show that value exactly 2 pixel periods after counter reaches (x,y); 0 in blank.
// - pixel_addr sequence per frame {0,0},{0,1}..{3,7}, one frame_start pulse per 112 pixels at {0,0} issue.
// - Assert rst at h=5,v=2 for 1 cycle -> next cycle counters (0,0); RGB=0, HS=VS=1 until pipeline refills.
// - blank=1 on frame 2 only -> RGB=0 whole frame 2, sync timing unchanged vs frame 1.
// - SCANOUT_PATTERN_EN, pattern_en=1, H_ACTIVE=8 -> pixel x shows bar x: R/G/B=3 where bit set, else 0.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA timing generator with a 2-stage fetch/output pipeline.
// Define SCANOUT_PATTERN_EN to build in 8-bar colour test pattern selected by pattern_en.
module vga_scanout #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int FETCH_LAT = 1,
  parameter int COLOR_W   = 1,
  parameter int X_W       = 11,
  parameter int Y_W       = 11,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [3*COLOR_W-1:0]   pixel_data,
  input  logic                   blank,
  input  logic                   pattern_en,
  output logic [X_W+Y_W-1:0]     pixel_addr,
  output logic [COLOR_W-1:0]     VGA_R,
  output logic [COLOR_W-1:0]     VGA_G,
  output logic [COLOR_W-1:0]     VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]  HS_BEG   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]  HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]  VS_BEG   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]  VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_ACTIVE > (1 << X_W)) begin : g_chk_x
    $error("vga_scanout: H_ACTIVE does not fit in X_W");
  end
  if (V_ACTIVE > (1 << Y_W)) begin : g_chk_y
    $error("vga_scanout: V_ACTIVE does not fit in Y_W");
  end
  if (CLK_DIV < 2 || FETCH_LAT >= CLK_DIV) begin : g_chk_div
    $error("vga_scanout: need CLK_DIV >= 2 and FETCH_LAT < CLK_DIV");
  end

  logic [DIV_W-1:0]       div_q, div_d;
  logic [HC_W-1:0]        h_q, h_d;
  logic [VC_W-1:0]        v_q, v_d;
  logic [X_W+Y_W-1:0]     addr_q, addr_d;
  logic                   act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [3*COLOR_W-1:0]   rgb_q, rgb_d;
  logic                   hs_q, hs_d, vs_q, vs_d;

  logic                   pix_en, active0, hs_raw, vs_raw;
  logic [3*COLOR_W-1:0]   src_rgb;

`ifdef SCANOUT_PATTERN_EN
  logic [X_W+2:0]         bar_num;
  logic [2:0]             bar_idx;
  logic [3*COLOR_W-1:0]   bar_rgb;

  // Bar index from the stage-1 x coordinate: x*8/H_ACTIVE.
  always_comb begin
    bar_num = {addr_q[X_W-1:0], 3'b000} / (X_W+3)'(H_ACTIVE);
    bar_idx = 3'(bar_num);
    bar_rgb = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
  end
`else
  logic pattern_unused;
  assign pattern_unused = pattern_en;
`endif

  always_comb begin
    pix_en  = (div_q == DIV_LAST);
    active0 = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw  = (h_q >= HS_BEG) && (h_q <= HS_END);
    vs_raw  = (v_q >= VS_BEG) && (v_q <= VS_END);

    div_d  = pix_en ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    act1_d = act1_q;
    hs1_d  = hs1_q;
    vs1_d  = vs1_q;
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;

    src_rgb = pixel_data;
`ifdef SCANOUT_PATTERN_EN
    if (pattern_en) src_rgb = bar_rgb;
`endif

    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      // Address is held outside the active area so the source sees no spurious fetches.
      if (active0) addr_d = {Y_W'(v_q), X_W'(h_q)};
      act1_d = active0;
      hs1_d  = hs_raw;
      vs1_d  = vs_raw;
      rgb_d  = (act1_q && !blank) ? src_rgb : '0;
      hs_d   = hs1_q ? HS_POL : ~HS_POL;
      vs_d   = vs1_q ? VS_POL : ~VS_POL;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      rgb_q  <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      act1_q <= act1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign pixel_addr  = addr_q;
  assign VGA_R       = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B       = rgb_q[COLOR_W-1:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign frame_start = pix_en && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout in a 14x8-total (8x4 visible) configuration, CLK_DIV=2.
// Source memory returns x+4*y one sysclk after the address is presented.
module tb_vga_scanout;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] pixel_data = '0;
  logic       blank = 1'b0;
  logic       pattern_en = 1'b0;
  logic [4:0] pixel_addr;
  logic [1:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, frame_start;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;          // sysclk edges since last reset edge
  int cyc = 0;        // absolute cycle count for sync interval checks
  int hs_fall = -1, vs_fall = -1;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .FETCH_LAT(1), .COLOR_W(2), .X_W(3), .Y_W(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .sysclk(sysclk), .rst(rst), .pixel_data(pixel_data), .blank(blank),
    .pattern_en(pattern_en), .pixel_addr(pixel_addr),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .frame_start(frame_start)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk)
    pixel_data <= 6'(pixel_addr[2:0]) + 6'({pixel_addr[4:3], 2'b00});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 0);
    chk({pfx, "_hs"}, 32'(VGA_HS), 1);
    chk({pfx, "_vs"}, 32'(VGA_VS), 1);
    chk({pfx, "_addr"}, 32'(pixel_addr), 0);
    chk({pfx, "_fs"}, 32'(frame_start), 0);
  endtask

  task automatic sync_track();
    if (hs_prev && !VGA_HS) begin
      if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, 28);
      hs_fall = cyc;
    end
    if (!hs_prev && VGA_HS && hs_fall >= 0) chk("hs_width", cyc - hs_fall, 6);
    if (vs_prev && !VGA_VS) begin
      if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, 224);
      vs_fall = cyc;
    end
    if (!vs_prev && VGA_VS && vs_fall >= 0) chk("vs_width", cyc - vs_fall, 56);
    hs_prev = VGA_HS;
    vs_prev = VGA_VS;
  endtask

  // bf: frame index (since reset) to blank, -1 for none; pat: expect colour bars.
  task automatic run(input int ncyc, input int bf, input bit pat);
    int n, m, c, h, v, r, hh, vv, e_rgb, e_addr;
    bit e_hs, e_vs, e_fs;
    for (int i = 0; i < ncyc; i++) begin
      m = (k + 2) / 2 - 2;
      blank = (m >= 0) && (m / 112 == bf);
      @(posedge sysclk);
      k++; cyc++;
      @(negedge sysclk);
      n = k / 2;
      m = n - 2;
      e_rgb = 0; e_hs = 1'b1; e_vs = 1'b1;
      if (m >= 0) begin
        h = m % 14;
        v = (m / 14) % 8;
        e_hs = !(h >= 10 && h <= 12);
        e_vs = !(v >= 5 && v <= 6);
        if (h < 8 && v < 4 && (m / 112) != bf)
          e_rgb = pat ? (((h >> 2) & 1) * 48 + ((h >> 1) & 1) * 12 + (h & 1) * 3) : h + 4 * v;
      end
      c = n - 1;
      e_addr = 0;
      if (c >= 0) begin
        r  = c % 112;
        hh = r % 14;
        vv = r / 14;
        e_addr = (vv >= 4) ? 31 : vv * 8 + ((hh < 8) ? hh : 7);
      end
      e_fs = (k % 2 == 1) && ((k / 2) % 112 == 0);
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), e_rgb);
      chk("hs", 32'(VGA_HS), 32'(e_hs));
      chk("vs", 32'(VGA_VS), 32'(e_vs));
      chk("addr", 32'(pixel_addr), e_addr);
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      sync_track();
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk_idle("reset");
    rst = 1'b0;
    k = 0;

    // Four frames; the second one (frame index 1) is blanked.
    run(4 * 224, 1, 1'b0);

    // Advance to h=5, v=2 of the current frame, then pulse reset for one cycle.
    run(66, -1, 1'b0);
    rst = 1'b1;
    @(posedge sysclk);
    cyc++;
    @(negedge sysclk);
    rst = 1'b0;
    k = 0;
    chk_idle("mid_reset");
    hs_fall = -1; vs_fall = -1;
    hs_prev = VGA_HS; vs_prev = VGA_VS;
    run(2 * 224, -1, 1'b0);

`ifdef SCANOUT_PATTERN_EN
    pattern_en = 1'b1;
    run(224, -1, 1'b1);
    pattern_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
